// File: rtl/cnt_pkg.sv
// Shared definitions for the Gray-code counter: direction encoding and the
// binary-to-Gray conversion used on the registered output path.
package cnt_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Sized for the widest legal counter; callers cast to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

endpackage

// File: rtl/cnt_prescale.sv
// Enable prescaler: emits a one-cycle step every PRESCALE enabled cycles.
// The count holds while en is low and restarts from zero on clr.
module cnt_prescale #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam logic [15:0] LP_LAST = 16'(PRESCALE - 1);

  logic [15:0] r_cnt;

  // step is combinational so the counter can act on it in the same cycle
  assign step = en && (r_cnt == LP_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= step ? '0 : r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/mod_gray_cnt.sv
// Modulo up/down counter with synchronous load, enable prescaler and
// registered binary, Gray and wrap-tick outputs.
module mod_gray_cnt
  import cnt_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  output logic [WIDTH-1:0] cnt_bin,
  output logic [WIDTH-1:0] cnt_gray,
  output logic             tick
);

  if (MODULUS > (64'd1 << WIDTH) || MODULUS < 2 || PRESCALE < 1 ||
      PRESCALE > 65535 || WIDTH < 2 || WIDTH > 32) begin : g_bad_param
    $error("mod_gray_cnt: illegal WIDTH/MODULUS/PRESCALE combination");
  end

  localparam logic [63:0]      LP_MOD = 64'(MODULUS);
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

  logic             w_step;
  logic [WIDTH-1:0] w_nxt;
  logic             w_tick;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tick;

  cnt_prescale #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (load),
    .step  (w_step)
  );

  // Wrap is decided on the current value, so nothing >= MODULUS is ever formed.
  always_comb begin
    w_nxt  = r_bin;
    w_tick = 1'b0;
    if (load) begin
      w_nxt = (64'(load_val) >= LP_MOD) ? LP_MAX : load_val;
    end else if (w_step) begin
      if (up == DIR_UP) begin
        if (r_bin == LP_MAX) begin
          w_nxt  = '0;
          w_tick = 1'b1;
        end else begin
          w_nxt = r_bin + WIDTH'(1);
        end
      end else begin
        if (r_bin == '0) begin
          w_nxt  = LP_MAX;
          w_tick = 1'b1;
        end else begin
          w_nxt = r_bin - WIDTH'(1);
        end
      end
    end
  end

  // Gray is taken from the next-state value so it lines up with cnt_bin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_tick <= 1'b0;
    end else begin
      r_bin  <= w_nxt;
      r_gray <= WIDTH'(bin2gray(32'(w_nxt)));
      r_tick <= w_tick;
    end
  end

  assign cnt_bin  = r_bin;
  assign cnt_gray = r_gray;
  assign tick     = r_tick;

endmodule

// File: tb/tb_mod_gray_cnt.sv
// Bench for mod_gray_cnt: three configurations driven from shared inputs,
// directed scenarios followed by random traffic against an arithmetic model.
module tb_mod_gray_cnt;

  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         en;
  logic         load;
  logic         up;
  logic [W-1:0] load_val;

  logic [W-1:0] o_bin  [3];
  logic [W-1:0] o_gray [3];
  logic         o_tick [3];

  mod_gray_cnt #(.WIDTH(W), .MODULUS(10), .PRESCALE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val), .up(up),
    .cnt_bin(o_bin[0]), .cnt_gray(o_gray[0]), .tick(o_tick[0]));

  mod_gray_cnt #(.WIDTH(W), .MODULUS(16), .PRESCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val), .up(up),
    .cnt_bin(o_bin[1]), .cnt_gray(o_gray[1]), .tick(o_tick[1]));

  mod_gray_cnt #(.WIDTH(W), .MODULUS(10), .PRESCALE(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val), .up(up),
    .cnt_bin(o_bin[2]), .cnt_gray(o_gray[2]), .tick(o_tick[2]));

  // reference model state
  int exp_bin  [3];
  int exp_pre  [3];
  int exp_tick [3];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic int mod_of(input int k);
    return (k == 1) ? 16 : 10;
  endfunction

  function automatic int pre_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int m;
      int p;
      m = mod_of(k);
      p = pre_of(k);
      exp_tick[k] = 0;
      if (!rst_n) begin
        exp_bin[k] = 0;
        exp_pre[k] = 0;
      end else if (load) begin
        exp_bin[k] = (int'(load_val) >= m) ? m - 1 : int'(load_val);
        exp_pre[k] = 0;
      end else if (en) begin
        if (exp_pre[k] == p - 1) begin
          exp_pre[k] = 0;
          if (up) begin
            exp_tick[k] = (exp_bin[k] == m - 1) ? 1 : 0;
            exp_bin[k]  = (exp_bin[k] + 1) % m;
          end else begin
            exp_tick[k] = (exp_bin[k] == 0) ? 1 : 0;
            exp_bin[k]  = (exp_bin[k] + m - 1) % m;
          end
        end else begin
          exp_pre[k] = exp_pre[k] + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int g;
      g = exp_bin[k] ^ (exp_bin[k] >> 1);
      chk($sformatf("bin%0d", k),  32'(o_bin[k]),  32'(exp_bin[k]));
      chk($sformatf("gray%0d", k), 32'(o_gray[k]), 32'(g));
      chk($sformatf("tick%0d", k), 32'(o_tick[k]), 32'(exp_tick[k]));
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [W-1:0] prev_gray;
    for (int k = 0; k < 3; k++) begin
      exp_bin[k] = 0; exp_pre[k] = 0; exp_tick[k] = 0;
    end

    // reset wins over load and enable
    rst_n = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd7; up = 1'b1;
    tick_cycle();
    tick_cycle();
    chk("rst_bin0", 32'(o_bin[0]), 32'd0);

    // count up 11 cycles from reset on modulus 10
    rst_n = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick_cycle();
      chk("up_seq_bin", 32'(o_bin[0]), 32'((i < 9) ? i + 1 : i - 9));
      chk("up_seq_tick", 32'(o_tick[0]), 32'((i == 9) ? 1 : 0));
    end

    // down wrap from 0
    load = 1'b1; load_val = 4'd0;
    tick_cycle();
    load = 1'b0; up = 1'b0;
    tick_cycle();
    chk("down_wrap_bin", 32'(o_bin[0]), 32'd9);
    chk("down_wrap_gray", 32'(o_gray[0]), 32'b1101);
    chk("down_wrap_tick", 32'(o_tick[0]), 32'd1);
    en = 1'b0;
    tick_cycle();
    chk("hold_tick", 32'(o_tick[0]), 32'd0);
    chk("hold_bin", 32'(o_bin[0]), 32'd9);

    // clamped load, then load beating a wrapping step
    load = 1'b1; load_val = 4'd12;
    tick_cycle();
    chk("clamp_bin", 32'(o_bin[0]), 32'd9);
    chk("clamp_bin_m16", 32'(o_bin[1]), 32'd12);
    en = 1'b1; up = 1'b1; load_val = 4'd3;
    tick_cycle();
    chk("load_win_bin", 32'(o_bin[0]), 32'd3);
    chk("load_win_tick", 32'(o_tick[0]), 32'd0);
    load = 1'b0;

    // prescale 3: 9 enabled, 4 idle, 3 enabled
    rst_n = 1'b0;
    tick_cycle();
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    repeat (9) tick_cycle();
    chk("pre_after9", 32'(o_bin[2]), 32'd3);
    en = 1'b0;
    repeat (4) begin
      tick_cycle();
      chk("pre_hold", 32'(o_bin[2]), 32'd3);
    end
    en = 1'b1;
    repeat (3) tick_cycle();
    chk("pre_resume", 32'(o_bin[2]), 32'd4);

    // Gray single-bit property across the 15 -> 0 wrap on modulus 16
    rst_n = 1'b0;
    tick_cycle();
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    prev_gray = o_gray[1];
    for (int i = 0; i < 20; i++) begin
      tick_cycle();
      chk("gray_onebit", 32'($countones(o_gray[1] ^ prev_gray)), 32'd1);
      if (i == 6) chk("gray_at7", 32'(o_gray[1]), 32'b0100);
      if (i == 15) chk("gray_wrap_tick", 32'(o_tick[1]), 32'd1);
      prev_gray = o_gray[1];
    end

    // reset with a step due at 5
    load = 1'b1; load_val = 4'd5; en = 1'b0;
    tick_cycle();
    load = 1'b0; en = 1'b1; rst_n = 1'b0;
    tick_cycle();
    chk("midrst_bin", 32'(o_bin[0]), 32'd0);
    chk("midrst_gray", 32'(o_gray[0]), 32'd0);
    chk("midrst_tick", 32'(o_tick[0]), 32'd0);
    rst_n = 1'b1;
    tick_cycle();
    chk("midrst_first", 32'(o_bin[0]), 32'd1);

    // random traffic
    repeat (400) begin
      rst_n    = ($urandom_range(0, 63) != 0);
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = W'($urandom_range(0, 15));
      up       = 1'($urandom_range(0, 1));
      tick_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
